// File: rtl/keypad_scanner_if.sv
// Keypad matrix pins and key-event outputs of the keypad scanner.
// The slave modport is the scanner side; master is the keypad/consumer side.
interface keypad_scanner_if;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  modport master (output row, input col, key_code, key_valid, key_held);
  modport slave  (input row, output col, key_code, key_valid, key_held);
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner: column walk, per-key debounce, one event per press.
// sw_clk is only sampled as a scan-rate enable; everything runs on clock_50m.
module keypad_scanner #(
  parameter int unsigned DEBOUNCE_TICKS = 3,
  parameter int unsigned RELEASE_TICKS  = 3
) (
  input  logic            clock_50m,
  input  logic            rst,
  input  logic            sw_clk,
  keypad_scanner_if.slave bus
);
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

  state_t           state, state_nxt;
  logic [1:0]       sw_sync;
  logic             sw_last;
  logic             tick;
  logic [3:0]       row_meta, row_stable;
  logic             hit;
  logic [1:0]       hit_row;
  logic [1:0]       col_idx, col_idx_nxt;
  logic [1:0]       cand_row, cand_row_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic             press_done, release_done;
  logic [3:0]       code_nxt;
  logic             valid_nxt, held_nxt;

  // Synchronizers and sw_clk rising-edge detect
  always_ff @(posedge clock_50m or negedge rst) begin
    if (!rst) begin
      sw_sync    <= 2'b00;
      sw_last    <= 1'b0;
      tick       <= 1'b0;
      row_meta   <= 4'b1111;
      row_stable <= 4'b1111;
    end else begin
      sw_sync    <= {sw_sync[0], sw_clk};
      sw_last    <= sw_sync[1];
      tick       <= sw_sync[1] & ~sw_last;
      row_meta   <= bus.row;
      row_stable <= row_meta;
    end
  end

  // Row decode, lowest row index wins
  always_comb begin
    hit     = ~&row_stable;
    hit_row = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!row_stable[i]) hit_row = 2'(i);
    end
  end

  assign cnt_inc      = cnt + CNT_W'(1);
  assign press_done   = (cnt_inc >= CNT_W'(DEBOUNCE_TICKS));
  assign release_done = (cnt_inc >= CNT_W'(RELEASE_TICKS));

  // State and registered outputs
  always_ff @(posedge clock_50m or negedge rst) begin
    if (!rst) begin
      state         <= SCAN;
      col_idx       <= 2'd0;
      cand_row      <= 2'd0;
      cnt           <= '0;
      bus.col       <= 4'b1110;
      bus.key_code  <= 4'd0;
      bus.key_valid <= 1'b0;
      bus.key_held  <= 1'b0;
    end else begin
      state         <= state_nxt;
      col_idx       <= col_idx_nxt;
      cand_row      <= cand_row_nxt;
      cnt           <= cnt_nxt;
      bus.col       <= ~(4'b0001 << col_idx_nxt);
      bus.key_code  <= code_nxt;
      bus.key_valid <= valid_nxt;
      bus.key_held  <= held_nxt;
    end
  end

  // Next state
  always_comb begin
    state_nxt = state;
    if (tick) begin
      case (state)
        SCAN: begin
          if (hit) state_nxt = (DEBOUNCE_TICKS <= 1) ? HELD : DEBOUNCE;
        end
        DEBOUNCE: begin
          if (!hit || (hit_row != cand_row)) state_nxt = SCAN;
          else if (press_done)               state_nxt = HELD;
        end
        HELD: begin
          if (!hit && release_done) state_nxt = SCAN;
        end
        default: state_nxt = SCAN;
      endcase
    end
  end

  // Datapath and output next values
  always_comb begin
    col_idx_nxt  = col_idx;
    cand_row_nxt = cand_row;
    cnt_nxt      = cnt;
    code_nxt     = bus.key_code;
    valid_nxt    = 1'b0;
    held_nxt     = bus.key_held;
    if (tick) begin
      case (state)
        SCAN: begin
          if (hit) begin
            cand_row_nxt = hit_row;
            cnt_nxt      = CNT_W'(1);
            if (DEBOUNCE_TICKS <= 1) begin
              code_nxt  = {hit_row, col_idx};
              valid_nxt = 1'b1;
              held_nxt  = 1'b1;
              cnt_nxt   = '0;
            end
          end else begin
            col_idx_nxt = col_idx + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (!hit || (hit_row != cand_row)) begin
            col_idx_nxt = col_idx + 2'd1;
            cnt_nxt     = '0;
          end else if (press_done) begin
            code_nxt  = {cand_row, col_idx};
            valid_nxt = 1'b1;
            held_nxt  = 1'b1;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
        HELD: begin
          if (hit) begin
            cnt_nxt = '0;
          end else if (release_done) begin
            held_nxt    = 1'b0;
            cnt_nxt     = '0;
            col_idx_nxt = col_idx + 2'd1;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
        default: cnt_nxt = '0;
      endcase
    end
  end
endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: keypad matrix model, directed table,
// reset corner case and random key activity checked against a per-tick model.
module tb_keypad_scanner;
  localparam int unsigned DEB = 3;
  localparam int unsigned REL = 3;

  logic        clock_50m = 1'b0;
  logic        rst       = 1'b0;
  logic        sw_clk    = 1'b0;
  logic [15:0] keys      = '0;
  int          vcount    = 0;
  int          vbase     = 0;
  int          tests     = 0;
  int          fails     = 0;

  keypad_scanner_if bus();

  keypad_scanner #(.DEBOUNCE_TICKS(DEB), .RELEASE_TICKS(REL)) dut (
    .clock_50m(clock_50m),
    .rst      (rst),
    .sw_clk   (sw_clk),
    .bus      (bus)
  );

  always #5 clock_50m = ~clock_50m;

  initial forever begin
    repeat (32) @(negedge clock_50m);
    sw_clk = ~sw_clk;
  end

  // Each pressed switch at (r,c) pulls row r low while column c is driven low
  function automatic logic [3:0] keypad_rows(input logic [15:0] k, input logic [3:0] c);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = ~|(k[i*4 +: 4] & ~c);
    return r;
  endfunction

  assign bus.row = keypad_rows(keys, bus.col);

  always @(posedge clock_50m) begin
    if (bus.key_valid === 1'b1) vcount <= vcount + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] col_of(input int c);
    logic [3:0] v;
    v = 4'hF;
    v[c] = 1'b0;
    return v;
  endfunction

  // Tick-level reference: mode 0 scanning, 1 confirming a press, 2 waiting for release
  int m_col, m_mode, m_row, m_cnt, m_code, m_pulse;
  bit m_held;

  function automatic int low_row(input logic [15:0] k, input int c);
    for (int r = 0; r < 4; r++) if (k[r*4 + c]) return r;
    return -1;
  endfunction

  task automatic model_reset();
    m_col = 0; m_mode = 0; m_row = 0; m_cnt = 0; m_code = 0; m_pulse = 0; m_held = 0;
  endtask

  task automatic model_accept();
    m_code = m_row * 4 + m_col; m_pulse = 1; m_held = 1; m_mode = 2; m_cnt = 0;
  endtask

  task automatic model_tick();
    int r;
    r = low_row(keys, m_col);
    m_pulse = 0;
    case (m_mode)
      0: if (r < 0) m_col = (m_col + 1) % 4;
         else begin
           m_row = r; m_cnt = 1;
           if (m_cnt >= int'(DEB)) model_accept(); else m_mode = 1;
         end
      1: if (r == m_row) begin
           m_cnt++;
           if (m_cnt >= int'(DEB)) model_accept();
         end else begin
           m_mode = 0; m_col = (m_col + 1) % 4;
         end
      default: if (r < 0) begin
           m_cnt++;
           if (m_cnt >= int'(REL)) begin m_held = 0; m_mode = 0; m_col = (m_col + 1) % 4; end
         end else m_cnt = 0;
    endcase
  endtask

  // Advance one scan tick and compare DUT against the model
  task automatic do_tick(input string tag);
    @(posedge sw_clk);
    repeat (8) @(posedge clock_50m);
    #1;
    model_tick();
    check({tag, ".col"},   int'(bus.col),      int'(col_of(m_col)));
    check({tag, ".code"},  int'(bus.key_code), m_code);
    check({tag, ".held"},  int'(bus.key_held), int'(m_held));
    check({tag, ".valid"}, vcount - vbase,     m_pulse);
    vbase = vcount;
  endtask

  typedef struct {
    logic [15:0] keys;
    int          ticks;
    logic [3:0]  col;
    logic [3:0]  code;
    bit          held;
    int          valid;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int vb0;
    vecs[0] = '{16'h0000, 4, 4'b1110, 4'd0, 1'b0, 0};  // idle walk, back to col 0
    vecs[1] = '{16'h0200, 4, 4'b1101, 4'd9, 1'b1, 1};  // row 2 / col 1 press
    vecs[2] = '{16'h0000, 2, 4'b1101, 4'd9, 1'b1, 0};  // short release
    vecs[3] = '{16'h0200, 1, 4'b1101, 4'd9, 1'b1, 0};  // re-press, no new event
    vecs[4] = '{16'h0000, 3, 4'b1011, 4'd9, 1'b0, 0};  // real release
    vecs[5] = '{16'h0080, 2, 4'b0111, 4'd9, 1'b0, 0};  // row 1 / col 3 seen once
    vecs[6] = '{16'h0000, 1, 4'b1110, 4'd9, 1'b0, 0};  // bounce drops out
    vecs[7] = '{16'h4004, 5, 4'b1011, 4'd2, 1'b1, 1};  // rows 0 and 3 in col 2
    vecs[8] = '{16'h0000, 3, 4'b0111, 4'd2, 1'b0, 0};

    model_reset();
    repeat (3) @(posedge clock_50m);
    #1;
    check("reset.col",   int'(bus.col),       4'hE);
    check("reset.code",  int'(bus.key_code),  0);
    check("reset.valid", int'(bus.key_valid), 0);
    check("reset.held",  int'(bus.key_held),  0);
    rst = 1'b1;
    vbase = vcount;

    foreach (vecs[i]) begin
      keys = vecs[i].keys;
      vb0  = vcount;
      repeat (vecs[i].ticks) do_tick($sformatf("vec%0d", i));
      check($sformatf("vec%0d.end_col", i),   int'(bus.col),      int'(vecs[i].col));
      check($sformatf("vec%0d.end_code", i),  int'(bus.key_code), int'(vecs[i].code));
      check($sformatf("vec%0d.end_held", i),  int'(bus.key_held), int'(vecs[i].held));
      check($sformatf("vec%0d.end_valid", i), vcount - vb0,       vecs[i].valid);
    end

    // Reset asserted while confirming a press on row 3 / col 3
    keys = 16'h8000;
    do_tick("pre_rst");
    check("pre_rst.col", int'(bus.col), 4'h7);
    @(negedge sw_clk);
    repeat (2) @(posedge clock_50m);
    rst = 1'b0;
    #1;
    check("midrst.col",   int'(bus.col),       4'hE);
    check("midrst.code",  int'(bus.key_code),  0);
    check("midrst.valid", int'(bus.key_valid), 0);
    check("midrst.held",  int'(bus.key_held),  0);
    repeat (3) @(posedge clock_50m);
    rst = 1'b1;
    keys = '0;
    model_reset();
    vbase = vcount;
    do_tick("post_rst");

    // Random key activity
    for (int t = 0; t < 80; t++) begin
      if ($urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 3))
          0:       keys = '0;
          1, 2:    keys = 16'(1) << $urandom_range(0, 15);
          default: keys = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
        endcase
      end
      do_tick("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
